// File: rtl/alu_share_arbiter_if.sv
// Request/response channel between one requester and the ALU share arbiter.
// The requester drives the master side; the arbiter uses the slave side.
interface alu_share_arbiter_if #(
   parameter int unsigned WIDTH = 32
);
   logic             req_valid;
   logic             req_ready;
   logic [3:0]       req_op;
   logic [WIDTH-1:0] req_a;
   logic [WIDTH-1:0] req_b;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_err;

   modport master (
      output req_valid, req_op, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one combinational ALU between two requesters.
// Each operation takes IDLE (accept) -> EXEC (drive ALU) -> RESP (hold result).
module alu_share_arbiter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   alu_share_arbiter_if.slave port0,
   alu_share_arbiter_if.slave port1,
   output logic [3:0]         alu_ctl,
   output logic [WIDTH-1:0]   alu_a,
   output logic [WIDTH-1:0]   alu_b,
   input  logic [WIDTH-1:0]   alu_result,
   input  logic               alu_zero
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam logic [3:0] ALU_IDLE = 4'd15;

   logic [1:0]       state_q, state_d;
   logic             last_grant_q;
   logic             owner_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [WIDTH-1:0] result_q;
   logic             zero_q, err_q;

   logic grant;
   logic accept;
   logic op_legal;
   logic rsp_done;

   function automatic logic is_legal(input logic [3:0] op);
      case (op)
         4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd12: is_legal = 1'b1;
         default:                             is_legal = 1'b0;
      endcase
   endfunction

   // On a tie the requester that was not served last wins.
   always_comb begin
      grant  = (port0.req_valid && port1.req_valid) ? ~last_grant_q : port1.req_valid;
      accept = (state_q == IDLE) && rst_n && (port0.req_valid || port1.req_valid);
   end

   assign port0.req_ready = accept && !grant;
   assign port1.req_ready = accept && grant;

   assign op_legal = is_legal(op_q);
   assign rsp_done = (state_q == RESP) && (owner_q ? port1.rsp_ready : port0.rsp_ready);

   assign port0.rsp_valid  = (state_q == RESP) && !owner_q;
   assign port1.rsp_valid  = (state_q == RESP) && owner_q;
   assign port0.rsp_result = result_q;
   assign port1.rsp_result = result_q;
   assign port0.rsp_zero   = zero_q;
   assign port1.rsp_zero   = zero_q;
   assign port0.rsp_err    = err_q;
   assign port1.rsp_err    = err_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = EXEC;
         EXEC:    state_d = RESP;
         RESP:    if (rsp_done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Illegal ops never reach the ALU; it sees the idle code instead.
   always_comb begin
      alu_ctl = ALU_IDLE;
      alu_a   = '0;
      alu_b   = '0;
      if (state_q == EXEC && op_legal) begin
         alu_ctl = op_q;
         alu_a   = a_q;
         alu_b   = b_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         op_q         <= 4'd0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         zero_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            owner_q <= grant;
            op_q    <= grant ? port1.req_op : port0.req_op;
            a_q     <= grant ? port1.req_a  : port0.req_a;
            b_q     <= grant ? port1.req_b  : port0.req_b;
         end
         if (state_q == EXEC) begin
            if (op_legal) begin
               result_q <= alu_result;
               zero_q   <= alu_zero;
               err_q    <= 1'b0;
            end else begin
               result_q <= '0;
               zero_q   <= 1'b0;
               err_q    <= 1'b1;
            end
         end
         if (rsp_done) last_grant_q <= owner_q;
      end
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
Time-shares the single ALU datapath between two requesters: the main pipeline (port 0) and the auxiliary sequencer (port 1). Each requester has a valid/ready request channel carrying the 4-bit ALU control code and operands, and a valid/ready response channel returning the result, zero flag and error flag. The block arbitrates round-robin, registers the operands, drives the ALU for one cycle, captures the result and holds it until the owner accepts it.

Parameters:
WIDTH, 32, operand/result width in bits.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req0_valid  in  1  requester 0 has an operation.
req0_ready  out  1  requester 0 operation accepted this cycle.
req0_op  in  4  ALU control code: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT, 12 NOR.
req0_a, req0_b  in  WIDTH  operands.
rsp0_valid  out  1  response for requester 0 is available.
rsp0_ready  in  1  requester 0 consumes the response.
rsp0_result  out  WIDTH  registered ALU result.
rsp0_zero  out  1  registered ALU zero flag.
rsp0_err  out  1  op code was illegal.
req1_* / rsp1_*  same set of signals as port 0, for requester 1.
alu_ctl  out  4  control code to the ALU; 15 when idle.
alu_a, alu_b  out  WIDTH  ALU operands.
alu_result  in  WIDTH  combinational ALU result.
alu_zero  in  1  combinational ALU zero flag.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all ready/valid outputs 0; rsp result/zero/err 0; alu_ctl=15; alu_a/alu_b=0; last_grant=1, so requester 0 wins the first tie. Reset mid-operation drops the in-flight operation silently and produces no response.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the requester not equal to last_grant.
  - reqN_ready=1 combinationally for the granted requester only; the other requester's ready stays 0.
  - On the handshake, latch op, a, b and owner into registers, then go to EXEC.
  - With no valid request, stay in IDLE.
- EXEC (exactly 1 cycle):
  - If the latched op is legal: alu_ctl=op, alu_a/alu_b=latched operands. At the clock edge, capture alu_result and alu_zero; err=0.
  - If the op is illegal (any code outside {0,1,2,6,7,12}): alu_ctl stays 15 and alu_a/alu_b stay 0; capture result=0, zero=0, err=1.
  - Go to RESP.
- Outside EXEC: alu_ctl=15, alu_a=0, alu_b=0.
- RESP:
  - rspN_valid=1 for the owner only.
  - result/zero/err stay stable while valid and not ready.
  - When rspN_ready=1: valid drops next cycle, last_grant=owner, go to IDLE.
- Requests never accepted in EXEC or RESP: both req ready outputs are 0 there.
- Latency:
  - Request accepted at edge T; EXEC during cycle T+1; rsp_valid high from cycle T+2.
  - Minimum issue interval is 3 cycles.
- rsp_result/zero/err are registered outputs, valid only while rsp_valid=1. Their values persist after the handshake but carry no meaning then.
- A requester may drop or change valid without a handshake; the block does not latch anything until the handshake.
- Widths: result is the raw WIDTH-bit ALU output, with no extension or truncation.

Test Plan:
1. req0 ADD: op=2, a=5, b=7, rsp0_ready=1 → req0_ready=1 in the IDLE cycle; alu_ctl=2 in the next cycle; rsp0_valid at T+2 with result=12, zero=0, err=0. rsp1_valid stays 0 throughout.
2. Both requesters valid from reset: req0 SUB 9-9, req1 OR 0xF0|0x0F → req0 is served first (result 0, zero=1), then req1 (result 0xFF). A re-asserted req0, contending with a still-valid req1, wins next because last_grant=1.
3. Backpressure: req1 SLT a=3, b=8 with rsp1_ready=0 for 4 cycles → rsp1_valid=1 with result=1 held stable. req0_valid asserted meanwhile sees req0_ready=0 until rsp1_ready=1, then is accepted in the following IDLE cycle.
4. Illegal op: req0 op=4 → alu_ctl stays 15 and alu_a/b=0 throughout; rsp0_valid with err=1, result=0, zero=0.
5. Reset mid-operation: assert rst_n=0 during EXEC → all outputs go to reset values asynchronously; after release, no rsp_valid appears, and the next request is accepted normally with req0 having tie priority.
6. Back-to-back on one port: req0 holds valid with three NOR ops, only req0 active → ops are accepted every 3 cycles; results of NOR 0,0 equal all-ones (zero=0).
